wb_stage_q: RTL
===============

Name: wb_stage_q

Overview:
- Parametrised writeback stage; successor to the fixed always-ready WB sink.
- Accepts MA->WB valid/ready transactions, selects the writeback value (ALU / load / link), and queues register writes in a DEPTH-entry pending buffer.
- Drains the buffer to a register-file write port that can apply backpressure (rf_wr_rdy).
- Exposes a pending-write hazard lookup for decode/forwarding, plus a retired-instruction counter.

Parameters:
- XLEN, 32, data/PC width.
- NREG, 16, architectural register count; AW = $clog2(NREG).
- DEPTH, 2, pending-write buffer entries (>=1).
- RA_IDX, NREG-1, link register index written by calls.
- LINK_OFS, 4, added to PC for call link value.
- CNTW, 32, retired counter width.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- Ma_Valid_i  in  1  MA payload valid.
- Ma_Ready_o  out  1  WB can accept.
- Ma_IsWb_i  in  1  instruction writes a register.
- Ma_IsCall_i  in  1  call; writes PC+LINK_OFS to RA_IDX.
- Ma_IsLd_i  in  1  load; writes Ma_LdData_i.
- Ma_Rd_i  in  AW  destination register (ignored when IsCall).
- Ma_AluRes_i  in  XLEN  ALU result.
- Ma_LdData_i  in  XLEN  load data.
- Ma_Pc_i  in  XLEN  instruction PC.
- rf_wr_en  out  1  head entry valid / write request.
- rf_wr_rdy  in  1  RF accepts write this cycle.
- rf_wr_addr  out  AW  head address.
- rf_wr_data  out  XLEN  head data.
- hz_addr_i  in  AW  hazard query register.
- hz_hit_o  out  1  query matches a pending entry.
- hz_data_o  out  XLEN  data of youngest matching entry.
- wb_cnt_o  out  $clog2(DEPTH+1)  occupancy.
- retired_o  out  CNTW  accepted-instruction count.

Behaviour:
- Reset: one clock clock edge with Rst=1 empties the buffer and clears all state. After that edge: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, wb_cnt_o=0, retired_o=0, hz_hit_o=0, hz_data_o=0, Ma_Ready_o=1. Any in-flight entry is discarded; reset mid-drain loses it.
- Ma_Ready_o = (count != DEPTH). It is a function of state only, with no combinational path from rf_wr_rdy.
- accept = Ma_Valid_i & Ma_Ready_o. On accept, retired_o increments by 1, wrapping modulo 2^CNTW.
- Enqueue on accept & (IsWb | IsCall):
  - addr = IsCall ? RA_IDX : Ma_Rd_i.
  - data selection: IsCall -> Ma_Pc_i+LINK_OFS (mod 2^XLEN); else IsLd -> Ma_LdData_i; else Ma_AluRes_i. IsCall has priority over IsLd.
  - Accepted non-writing instructions do not enqueue.
- Drain:
  - rf_wr_en = !empty; rf_wr_addr/rf_wr_data = head entry, driven from registered storage.
  - Pop when rf_wr_en & rf_wr_rdy.
  - rf_wr_rdy=0 holds the head stable and buffers up to DEPTH writes.
- Latency: an entry enqueued at edge N is presented on the RF port in cycle N+1 (one-cycle registered, matching the previous generation). With rf_wr_rdy=1 it is written at edge N+1.
- Occupancy:
  - Push and pop in the same cycle: count unchanged, read/write pointers both advance.
  - Push is impossible when full, since Ready=0.
  - Pop when empty is impossible, since rf_wr_en=0.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
- Order: writes leave in acceptance order; duplicate addresses are both written, in order.
- Hazard lookup (combinational on hz_addr_i and the buffer):
  - hz_hit_o=1 if any valid entry has addr==hz_addr_i.
  - hz_data_o = data of the youngest such entry, else 0.
  - The head entry popping this cycle still counts.
  - The incoming (not yet enqueued) payload is not searched.

Decomposition:
- cpu_pkg additions: wb_sel_e {WB_ALU, WB_LD, WB_LINK}; wb_entry_t is not used (widths are parametrised). Entries are packed as {addr[AW], data[XLEN]} locally.
- One sub-module: wb_pend_buf, a DEPTH-entry circular buffer with push/pop/count and a per-entry valid/addr/data view. The youngest-match search lives in wb_stage_q.

Test Plan:
- Reset, then an ALU op (Rd=3, AluRes=0x1234, IsWb=1) with rf_wr_rdy=1 -> next cycle rf_wr_en=1, addr=3, data=0x1234; following cycle rf_wr_en=0; retired_o=1.
- Call at Pc=0x100 with IsLd=1 also set -> addr=15, data=0x104 (call beats load); load Rd=5, LdData=0xCAFE -> data=0xCAFE.
- Backpressure, rf_wr_rdy=0: write r1=0xA, r2=0xB -> wb_cnt_o=2, Ma_Ready_o=0, third valid held. rf_wr_rdy=1 -> r1, r2, then r3 written in order; Ready returns to 1 the cycle after the first pop.
- Hazard with rf_wr_rdy=0: buffer holds r7=0x11 then r7=0x22; hz_addr_i=7 -> hit=1, data=0x22; hz_addr_i=8 -> hit=0, data=0.
- Non-writing instruction (IsWb=0, IsCall=0) accepted -> no rf_wr_en, retired_o increments. With CNTW=4, 16 accepts -> retired_o wraps to 0.
- Rst asserted while 2 entries are pending -> after the edge rf_wr_en=0, wb_cnt_o=0, and no stale write appears after Rst deasserts.

Source files
------------

// File: rtl/wb_stage_q_pkg.sv
// Shared types for the writeback stage: value-source select and its decode.
package wb_stage_q_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LD   = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    // A call always writes the link value, even if the load flag is also set.
    function automatic wb_sel_e wb_sel_f(input logic is_call, input logic is_ld);
        if (is_call)
            return WB_LINK;
        else if (is_ld)
            return WB_LD;
        else
            return WB_ALU;
    endfunction

endpackage

// File: rtl/wb_pend_buf.sv
// DEPTH-entry circular buffer of pending register writes with a per-entry view
// so the stage can search outstanding writes for hazards.
module wb_pend_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 4,
    parameter int XLEN  = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              push_addr,
    input  logic [XLEN-1:0]            push_data,
    output logic [CW-1:0]              cnt,
    output logic                       full,
    output logic                       empty,
    output logic [PW-1:0]              rd_ptr,
    output logic [AW-1:0]              head_addr,
    output logic [XLEN-1:0]            head_data,
    output logic [DEPTH-1:0]           ent_vld,
    output logic [DEPTH-1:0][AW-1:0]   ent_addr,
    output logic [DEPTH-1:0][XLEN-1:0] ent_data
);

    logic [PW-1:0]              wr_ptr;
    logic [DEPTH-1:0]           vld_q;
    logic [DEPTH-1:0][AW-1:0]   addr_q;
    logic [DEPTH-1:0][XLEN-1:0] data_q;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (push) begin
                vld_q[wr_ptr]  <= 1'b1;
                addr_q[wr_ptr] <= push_addr;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign ent_vld   = vld_q;
    assign ent_addr  = addr_q;
    assign ent_data  = data_q;

endmodule

// File: rtl/wb_stage_q.sv
// Writeback stage: selects the writeback value, queues register writes and
// drains them to a backpressured RF port; also offers a pending-write lookup.
module wb_stage_q
    import wb_stage_q_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 16,
    parameter int DEPTH    = 2,
    parameter int RA_IDX   = NREG - 1,
    parameter int LINK_OFS = 4,
    parameter int CNTW     = 32,
    localparam int AW      = $clog2(NREG),
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Ma_Valid_i,
    output logic            Ma_Ready_o,
    input  logic            Ma_IsWb_i,
    input  logic            Ma_IsCall_i,
    input  logic            Ma_IsLd_i,
    input  logic [AW-1:0]   Ma_Rd_i,
    input  logic [XLEN-1:0] Ma_AluRes_i,
    input  logic [XLEN-1:0] Ma_LdData_i,
    input  logic [XLEN-1:0] Ma_Pc_i,
    output logic            rf_wr_en,
    input  logic            rf_wr_rdy,
    output logic [AW-1:0]   rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    input  logic [AW-1:0]   hz_addr_i,
    output logic            hz_hit_o,
    output logic [XLEN-1:0] hz_data_o,
    output logic [CW-1:0]   wb_cnt_o,
    output logic [CNTW-1:0] retired_o
);

    wb_sel_e                    sel;
    logic                       accept;
    logic                       push;
    logic                       pop;
    logic [AW-1:0]              push_addr;
    logic [XLEN-1:0]            push_data;
    logic                       full;
    logic                       empty;
    logic [PW-1:0]              rd_ptr;
    logic [AW-1:0]              head_addr;
    logic [XLEN-1:0]            head_data;
    logic [DEPTH-1:0]           ent_vld;
    logic [DEPTH-1:0][AW-1:0]   ent_addr;
    logic [DEPTH-1:0][XLEN-1:0] ent_data;

    // Ready depends on occupancy only, so rf_wr_rdy never reaches Ma_Ready_o.
    assign Ma_Ready_o = !full;
    assign accept     = Ma_Valid_i & Ma_Ready_o;
    assign push       = accept & (Ma_IsWb_i | Ma_IsCall_i);
    assign pop        = rf_wr_en & rf_wr_rdy;

    always_comb begin
        sel       = wb_sel_f(Ma_IsCall_i, Ma_IsLd_i);
        push_addr = Ma_IsCall_i ? AW'(RA_IDX) : Ma_Rd_i;
        case (sel)
            WB_LINK: push_data = Ma_Pc_i + XLEN'(LINK_OFS);
            WB_LD:   push_data = Ma_LdData_i;
            default: push_data = Ma_AluRes_i;
        endcase
    end

    wb_pend_buf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .XLEN  (XLEN)
    ) u_buf (
        .clk       (Clk),
        .rst       (Rst),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .push_data (push_data),
        .cnt       (wb_cnt_o),
        .full      (full),
        .empty     (empty),
        .rd_ptr    (rd_ptr),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_vld   (ent_vld),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data)
    );

    // Slots keep stale contents after a pop; mask them while nothing is queued.
    assign rf_wr_en   = !empty;
    assign rf_wr_addr = empty ? '0 : head_addr;
    assign rf_wr_data = empty ? '0 : head_data;

    // Walk oldest to youngest from the read pointer; the last match wins.
    always_comb begin
        int            j;
        logic [PW-1:0] idx;
        hz_hit_o  = 1'b0;
        hz_data_o = '0;
        j         = 0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            j = int'(rd_ptr) + k;
            if (j >= DEPTH)
                j = j - DEPTH;
            idx = PW'(j);
            if (ent_vld[idx] && (ent_addr[idx] == hz_addr_i)) begin
                hz_hit_o  = 1'b1;
                hz_data_o = ent_data[idx];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            retired_o <= '0;
        else if (accept)
            retired_o <= retired_o + CNTW'(1);
    end

endmodule
